// File: rtl/ac97_csr_pkg.sv
// Shared definitions for the AC97 DMA CSR slave: register offsets, channel
// state encoding, per-channel command bundle and the word address step.
package ac97_csr_pkg;

  localparam int unsigned OFS_CTRL       = 'h00;
  localparam int unsigned OFS_STATUS     = 'h04;
  localparam int unsigned OFS_DMAR_START = 'h10;
  localparam int unsigned OFS_DMAR_ADDR  = 'h14;
  localparam int unsigned OFS_DMAR_COUNT = 'h18;
  localparam int unsigned OFS_DMAW_START = 'h20;
  localparam int unsigned OFS_DMAW_ADDR  = 'h24;
  localparam int unsigned OFS_DMAW_COUNT = 'h28;

  // Byte step between consecutive 32-bit words.
  localparam int unsigned ADDR_INC = 4;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_BUSY = 2'd1,
    CH_DONE = 2'd2
  } chan_state_e;

  // Decoded CSR strobes for one channel; all share the CSR data word.
  typedef struct packed {
    logic start_wr;
    logic addr_wr;
    logic count_wr;
    logic abort;
  } chan_cmd_t;

endpackage

// File: rtl/ac97_dma_chan.sv
// One DMA word-transfer channel: address/count registers, IDLE/BUSY/DONE FSM,
// word request handshake and a one-cycle completion pulse.
module ac97_dma_chan
  import ac97_csr_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  chan_cmd_t         cmd,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ack,
  output logic              req,
  output logic [DATA_W-1:0] addr,
  output logic              irq
);

  chan_state_e      state;
  logic [CNT_W-1:0] count;

  // Channel FSM with registered req/addr/irq; abort takes priority over completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CH_IDLE;
      count <= '0;
      addr  <= '0;
      req   <= 1'b0;
      irq   <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (state != CH_BUSY) begin
        if (cmd.addr_wr)  addr  <= wdata;
        if (cmd.count_wr) count <= wdata[CNT_W-1:0];
      end
      case (state)
        CH_IDLE: begin
          if (cmd.start_wr && wdata[0] && en) begin
            if (count != '0) begin
              state <= CH_BUSY;
              req   <= 1'b1;
            end else begin
              state <= CH_DONE;
            end
          end
        end
        CH_BUSY: begin
          if (ack) begin
            addr  <= addr + DATA_W'(ADDR_INC);
            count <= count - CNT_W'(1);
          end
          if (cmd.abort) begin
            state <= CH_IDLE;
            req   <= 1'b0;
          end else if (ack && (count == CNT_W'(1))) begin
            state <= CH_DONE;
            req   <= 1'b0;
          end
        end
        CH_DONE: begin
          irq   <= 1'b1;
          state <= CH_IDLE;
        end
        default: begin
          state <= CH_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ac97_dma_csr_slave.sv
// AC97 DMA CSR slave: decodes write-only CSRs from the crreq command bus and
// runs independent playback (dmar) and record (dmaw) word-transfer channels.
// Optional build macro AC97_IRQ_STATUS_EN adds a sticky write-1-clear STATUS
// register at 0x04 and turns both irqs into levels mirroring its bits.
module ac97_dma_csr_slave
  import ac97_csr_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              crreq,
  input  logic [ADDR_W-1:0] csr_addr,
  input  logic [DATA_W-1:0] csr_data,
  output logic              dmar_req,
  output logic [DATA_W-1:0] dmar_addr,
  input  logic              dmar_ack,
  output logic              dmaw_req,
  output logic [DATA_W-1:0] dmaw_addr,
  input  logic              dmaw_ack,
  output logic              dmar_irq,
  output logic              dmaw_irq
);

  logic      dmar_en;
  logic      dmaw_en;
  logic      sel_ctrl;
  chan_cmd_t cmd_r;
  chan_cmd_t cmd_w;
  logic      r_done;
  logic      w_done;

  assign sel_ctrl = crreq && (csr_addr == ADDR_W'(OFS_CTRL));

  // Per-channel write strobes; clearing an enable bit doubles as abort.
  always_comb begin
    cmd_r          = '0;
    cmd_w          = '0;
    cmd_r.start_wr = crreq && (csr_addr == ADDR_W'(OFS_DMAR_START));
    cmd_r.addr_wr  = crreq && (csr_addr == ADDR_W'(OFS_DMAR_ADDR));
    cmd_r.count_wr = crreq && (csr_addr == ADDR_W'(OFS_DMAR_COUNT));
    cmd_r.abort    = sel_ctrl && !csr_data[0];
    cmd_w.start_wr = crreq && (csr_addr == ADDR_W'(OFS_DMAW_START));
    cmd_w.addr_wr  = crreq && (csr_addr == ADDR_W'(OFS_DMAW_ADDR));
    cmd_w.count_wr = crreq && (csr_addr == ADDR_W'(OFS_DMAW_COUNT));
    cmd_w.abort    = sel_ctrl && !csr_data[1];
  end

  // CTRL register: channel enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmar_en <= 1'b0;
      dmaw_en <= 1'b0;
    end else if (sel_ctrl) begin
      dmar_en <= csr_data[0];
      dmaw_en <= csr_data[1];
    end
  end

  ac97_dma_chan #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dmar (
    .clk   (clk),
    .rst   (rst),
    .en    (dmar_en),
    .cmd   (cmd_r),
    .wdata (csr_data),
    .ack   (dmar_ack),
    .req   (dmar_req),
    .addr  (dmar_addr),
    .irq   (r_done)
  );

  ac97_dma_chan #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dmaw (
    .clk   (clk),
    .rst   (rst),
    .en    (dmaw_en),
    .cmd   (cmd_w),
    .wdata (csr_data),
    .ack   (dmaw_ack),
    .req   (dmaw_req),
    .addr  (dmaw_addr),
    .irq   (w_done)
  );

`ifdef AC97_IRQ_STATUS_EN
  logic [1:0] status;
  logic       sel_status;

  assign sel_status = crreq && (csr_addr == ADDR_W'(OFS_STATUS));

  // Sticky completion flags; write-1-clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
    end else begin
      status[0] <= (sel_status && csr_data[0]) ? 1'b0 : (status[0] | r_done);
      status[1] <= (sel_status && csr_data[1]) ? 1'b0 : (status[1] | w_done);
    end
  end

  assign dmar_irq = status[0];
  assign dmaw_irq = status[1];
`else
  assign dmar_irq = r_done;
  assign dmaw_irq = w_done;
`endif

endmodule

// File: tb/tb_ac97_dma_csr_slave.sv
// Scoreboard bench for ac97_dma_csr_slave (default build: pulse irqs).
// The driver applies CSR writes to a transaction-level model that queues the
// expected word addresses and irq cycles; a negedge monitor compares them.
`timescale 1ns/1ps
module tb_ac97_dma_csr_slave;

  localparam logic [13:0] A_CTRL   = 14'h00;
  localparam logic [13:0] A_RSTART = 14'h10;
  localparam logic [13:0] A_RADDR  = 14'h14;
  localparam logic [13:0] A_RCOUNT = 14'h18;
  localparam logic [13:0] A_WSTART = 14'h20;
  localparam logic [13:0] A_WADDR  = 14'h24;
  localparam logic [13:0] A_WCOUNT = 14'h28;
  localparam logic [13:0] A_UNMAP  = 14'h3C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crreq = 1'b0;
  logic [13:0] csr_addr = '0;
  logic [31:0] csr_data = '0;
  logic        dmar_req, dmaw_req, dmar_irq, dmaw_irq;
  logic [31:0] dmar_addr, dmaw_addr;
  logic        dmar_ack = 1'b0;
  logic        dmaw_ack = 1'b0;

  ac97_dma_csr_slave dut (
    .clk       (clk),
    .rst       (rst),
    .crreq     (crreq),
    .csr_addr  (csr_addr),
    .csr_data  (csr_data),
    .dmar_req  (dmar_req),
    .dmar_addr (dmar_addr),
    .dmar_ack  (dmar_ack),
    .dmaw_req  (dmaw_req),
    .dmaw_addr (dmaw_addr),
    .dmaw_ack  (dmaw_ack),
    .dmar_irq  (dmar_irq),
    .dmaw_irq  (dmaw_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: index 0 = playback, 1 = record.
  logic [31:0] beat_q [2][$];
  int          irq_q  [2][$];
  int          done_cyc [2] = '{-10, -10};
  int          last_irq [2] = '{-1, -2};
  logic [31:0] m_addr   [2] = '{32'h0, 32'h0};
  logic [15:0] m_count  [2] = '{16'h0, 16'h0};
  logic        m_en     [2] = '{1'b0, 1'b0};
  int          ack_mode [2] = '{0, 0};  // 0 low, 1 high, 2 random, 3 every third

  task automatic check(input string name, input int ch, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s ch%0d cyc%0d: got 0x%08h expected 0x%08h", name, ch, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      beat_q[c].delete();
      irq_q[c].delete();
      done_cyc[c] = -10;
      m_addr[c]   = '0;
      m_count[c]  = '0;
      m_en[c]     = 1'b0;
    end
  endtask

  // One CSR write in the current cycle, then apply its effect to the model.
  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    int   k;
    logic busy [2];
    logic in_done [2];
    k = cyc;
    for (int c = 0; c < 2; c++) begin
      busy[c]    = beat_q[c].size() != 0;
      in_done[c] = (k == done_cyc[c]);
    end
    crreq    = 1'b1;
    csr_addr = a;
    csr_data = d;
    tick();
    crreq = 1'b0;
    for (int c = 0; c < 2; c++) begin
      logic [13:0] ofs_base;
      ofs_base = (c == 0) ? 14'h10 : 14'h20;
      if (a == A_CTRL) begin
        if (busy[c] && !d[c]) begin
          if (beat_q[c].size() != 0) begin
            m_addr[c]  = beat_q[c][0];
            m_count[c] = 16'(beat_q[c].size());
          end else begin
            m_count[c] = '0;
            irq_q[c].delete();
            done_cyc[c] = -10;
          end
          beat_q[c].delete();
        end
        m_en[c] = d[c];
      end else if (a == ofs_base + 14'h4) begin
        if (!busy[c]) m_addr[c] = d;
      end else if (a == ofs_base + 14'h8) begin
        if (!busy[c]) m_count[c] = d[15:0];
      end else if (a == ofs_base) begin
        if (!busy[c] && !in_done[c] && m_en[c] && d[0]) begin
          if (m_count[c] == 0) begin
            irq_q[c].push_back(k + 2);
            done_cyc[c] = k + 1;
          end else begin
            for (int i = 0; i < int'(m_count[c]); i++) begin
              beat_q[c].push_back(m_addr[c]);
              m_addr[c] = m_addr[c] + 32'd4;
            end
            m_count[c] = '0;
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int c, input int budget);
    int n;
    n = 0;
    while ((beat_q[c].size() != 0 || irq_q[c].size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_in_budget", c, 32'(beat_q[c].size() + irq_q[c].size()), 32'd0);
    beat_q[c].delete();
    irq_q[c].delete();
    tick();
  endtask

  // Ack generators, driven after the driver's writes in each cycle.
  initial forever begin
    @(posedge clk);
    #2;
    for (int c = 0; c < 2; c++) begin
      logic a;
      case (ack_mode[c])
        1:       a = 1'b1;
        2:       a = 1'($urandom_range(0, 1));
        3:       a = ((cyc % 3) == 2);
        default: a = 1'b0;
      endcase
      if (c == 0) dmar_ack = a;
      else        dmaw_ack = a;
    end
  end

  // Monitor: compare req/addr beats and irq timing against the scoreboard.
  logic        req_v [2];
  logic        ack_v [2];
  logic        irq_v [2];
  logic [31:0] addr_v [2];
  int          exp_irq;
  always @(negedge clk) begin
    req_v[0] = dmar_req;  req_v[1] = dmaw_req;
    ack_v[0] = dmar_ack;  ack_v[1] = dmaw_ack;
    irq_v[0] = dmar_irq;  irq_v[1] = dmaw_irq;
    addr_v[0] = dmar_addr; addr_v[1] = dmaw_addr;
    for (int c = 0; c < 2; c++) begin
      check("req", c, 32'(req_v[c]), 32'(beat_q[c].size() != 0));
      if (req_v[c] && beat_q[c].size() != 0) begin
        check("addr", c, addr_v[c], beat_q[c][0]);
        if (ack_v[c] && !rst) begin
          void'(beat_q[c].pop_front());
          if (beat_q[c].size() == 0) begin
            irq_q[c].push_back(cyc + 2);
            done_cyc[c] = cyc + 1;
          end
        end
      end
      if (irq_v[c]) begin
        exp_irq = (irq_q[c].size() != 0) ? irq_q[c][0] : -1;
        check("irq_cycle", c, 32'(cyc), 32'(exp_irq));
        if (irq_q[c].size() != 0) void'(irq_q[c].pop_front());
        last_irq[c] = cyc;
      end else if (irq_q[c].size() != 0 && irq_q[c][0] <= cyc) begin
        check("irq_level", c, 32'(irq_v[c]), 32'd1);
        void'(irq_q[c].pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] rnd_ofs [10];
    int          n;
    rnd_ofs = '{A_RADDR, A_RCOUNT, A_RSTART, A_WADDR, A_WCOUNT, A_WSTART,
                A_UNMAP, 14'h04, 14'h08, A_CTRL};

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst_dmar_req", 0, 32'(dmar_req), 32'd0);
    check("rst_dmaw_req", 1, 32'(dmaw_req), 32'd0);
    check("rst_dmar_addr", 0, dmar_addr, 32'd0);
    check("rst_dmaw_addr", 1, dmaw_addr, 32'd0);
    check("rst_dmar_irq", 0, 32'(dmar_irq), 32'd0);
    check("rst_dmaw_irq", 1, 32'(dmaw_irq), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick();

    // Playback, three words, ack tied high; random acks on idle record side.
    ack_mode = '{1, 2};
    csr_wr(A_CTRL, 32'h1);
    csr_wr(A_RADDR, 32'h1000);
    csr_wr(A_RCOUNT, 32'd3);
    csr_wr(A_RSTART, 32'h1);
    wait_idle(0, 50);

    // Record with stalls and address wrap.
    ack_mode = '{0, 3};
    csr_wr(A_CTRL, 32'h2);
    csr_wr(A_WADDR, 32'hFFFF_FFFC);
    csr_wr(A_WCOUNT, 32'd2);
    csr_wr(A_WSTART, 32'h1);
    wait_idle(1, 50);

    // Zero count: completion pulse without any request.
    csr_wr(A_CTRL, 32'h3);
    csr_wr(A_RCOUNT, 32'd0);
    csr_wr(A_RSTART, 32'h1);
    wait_idle(0, 20);

    // Abort mid-transfer, then a START with en=0 is ignored.
    ack_mode = '{2, 0};
    csr_wr(A_CTRL, 32'h1);
    csr_wr(A_RADDR, $urandom);
    csr_wr(A_RCOUNT, 32'd10);
    csr_wr(A_RSTART, 32'h1);
    n = 0;
    while (beat_q[0].size() > 6 && n < 200) begin tick(); n++; end
    check("abort_progress", 0, 32'(beat_q[0].size() <= 6), 32'd1);
    csr_wr(A_CTRL, 32'h0);
    csr_wr(A_RSTART, 32'h1);
    repeat (6) tick();
    check("abort_req", 0, 32'(dmar_req), 32'd0);

    // Concurrent channels with equal counts, plus ignored and unmapped writes.
    ack_mode = '{0, 0};
    n = $urandom_range(2, 6);
    csr_wr(A_CTRL, 32'h3);
    csr_wr(A_RADDR, $urandom);
    csr_wr(A_WADDR, $urandom);
    csr_wr(A_RCOUNT, 32'(n));
    csr_wr(A_WCOUNT, 32'(n));
    csr_wr(A_RSTART, 32'h1);
    csr_wr(A_WSTART, 32'h1);
    csr_wr(A_RADDR, $urandom);
    csr_wr(A_UNMAP, $urandom);
    ack_mode = '{1, 1};
    wait_idle(0, 50);
    wait_idle(1, 50);
    check("irq_same_cycle", 0, 32'(last_irq[0]), 32'(last_irq[1]));

    // Randomized transactions.
    for (int it = 0; it < 24; it++) begin
      ack_mode[0] = $urandom_range(1, 3);
      ack_mode[1] = $urandom_range(1, 3);
      csr_wr(A_CTRL, 32'($urandom_range(0, 3)));
      csr_wr(A_RADDR, $urandom);
      csr_wr(A_WADDR, $urandom);
      csr_wr(A_RCOUNT, 32'($urandom_range(0, 6)));
      csr_wr(A_WCOUNT, 32'($urandom_range(0, 6)));
      csr_wr(A_RSTART, 32'($urandom_range(0, 3)));
      csr_wr(A_WSTART, 32'($urandom_range(0, 3)));
      for (int j = 0; j < 2; j++) begin
        csr_wr(rnd_ofs[$urandom_range(0, 9)], $urandom);
      end
      wait_idle(0, 200);
      wait_idle(1, 200);
    end

    // Reset mid-transfer, then START from reset values is ignored.
    ack_mode = '{2, 1};
    csr_wr(A_CTRL, 32'h1);
    csr_wr(A_RADDR, $urandom);
    csr_wr(A_RCOUNT, 32'd20);
    csr_wr(A_RSTART, 32'h1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_dmar_addr", 0, dmar_addr, 32'd0);
    check("midrst_dmaw_addr", 1, dmaw_addr, 32'd0);
    check("midrst_dmar_irq", 0, 32'(dmar_irq), 32'd0);
    @(posedge clk);
    #1;
    csr_wr(A_RSTART, 32'h1);
    csr_wr(A_WSTART, 32'h1);
    repeat (6) tick();

    for (int c = 0; c < 2; c++) begin
      check("leftover", c, 32'(beat_q[c].size() + irq_q[c].size()), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ac97_dma_csr_slave.md
Name: ac97_dma_csr_slave

Overview:
- CSR write responder at the far end of the AC97 controller's crreq/csr_addr/csr_data command bus.
- Decodes the control, playback (DMA read) and record (DMA write) registers, and runs two independent word-transfer channels toward the memory/FIFO side.
- Raises dmar_irq and dmaw_irq, which feed back to the controller.

Parameters:
- ADDR_W, 14, CSR address width.
- DATA_W, 32, CSR data and DMA address width.
- CNT_W, 16, width of the per-channel remaining-word counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- crreq  in  1  CSR write strobe; every cycle it is high is one write.
- csr_addr  in  ADDR_W  CSR byte offset.
- csr_data  in  DATA_W  CSR write data.
- dmar_req  out  1  playback word request.
- dmar_addr  out  DATA_W  playback word address.
- dmar_ack  in  1  playback word accepted.
- dmaw_req  out  1  record word request.
- dmaw_addr  out  DATA_W  record word address.
- dmaw_ack  in  1  record word accepted.
- dmar_irq  out  1  playback transfer complete.
- dmaw_irq  out  1  record transfer complete.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: all registers, req, addr and irq outputs are 0; both channels are IDLE.
- Register map (write-only). Writes commit on the clk edge where crreq=1. Unmapped offsets are ignored.
  - 0x00 CTRL: bit0 = dmar_en, bit1 = dmaw_en.
  - 0x10 DMAR_START: bit0=1 starts playback.
  - 0x14 DMAR_ADDR.
  - 0x18 DMAR_COUNT: low CNT_W bits.
  - 0x20 DMAW_START: bit0=1 starts record.
  - 0x24 DMAW_ADDR.
  - 0x28 DMAW_COUNT.
- Per-channel FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY: on a START write with en=1 and COUNT != 0. req rises the cycle after the write commits; addr = ADDR register.
  - IDLE -> DONE: on a START write with en=1 and COUNT = 0. No req is issued.
  - START with en=0: ignored.
  - BUSY: req is held high and addr is stable until ack is sampled high.
    - On ack: addr += 4 (mod 2^32), COUNT -= 1.
    - If COUNT was 1, req drops the next cycle and the FSM goes to DONE.
    - Otherwise req stays high with the new addr (back-to-back; one word per cycle maximum).
  - DONE: irq is high for exactly one cycle, then the FSM returns to IDLE.
  - ack while req=0: ignored.
- Writes to ADDR, COUNT or START while BUSY are ignored.
- Clearing en via CTRL while BUSY aborts: req drops the next cycle, FSM goes to IDLE, no irq. An ack in the same cycle as the clearing write is still counted.
- The two channels are fully independent. Simultaneous completion pulses both irqs in the same cycle.
- rst asserted mid-transfer: everything returns to reset values next edge. No irq.

Optional Feature:
- Macro: AC97_IRQ_STATUS_EN.
- Defined:
  - Adds a sticky STATUS register at 0x04: bit0 = dmar_done, bit1 = dmaw_done.
  - dmar_irq and dmaw_irq become levels equal to the corresponding status bit.
  - Writing 1 to a bit clears it; write-1-clear takes priority over a same-cycle set.
- Undefined: 0x04 is unmapped, and irqs are single-cycle pulses as above.

Decomposition:
- Package ac97_csr_pkg:
  - Register offset constants: CTRL, STATUS, DMAR_START/ADDR/COUNT, DMAW_START/ADDR/COUNT.
  - Channel state encoding: IDLE/BUSY/DONE.
  - Address increment constant: 4.
- Sub-module ac97_dma_chan: FSM, address/count registers, req/irq. Instantiated twice (playback, record).
- Top level: CSR decode and CTRL/STATUS.

Test Plan:
- Playback, 3 words: write 0x00=1, 0x14=0x1000, 0x18=3, 0x10=1 with ack tied high -> dmar_addr 0x1000, 0x1004, 0x1008 on consecutive cycles; req low after; one-cycle dmar_irq; dmaw_req stays 0.
- Record with ack stalls: 0x00=2, 0x24=0xFFFFFFFC, 0x28=2, 0x20=1; ack every third cycle -> addr held during stalls, then wraps to 0x00000000; dmaw_irq after the second ack.
- Zero count: DMAR_COUNT=0, START -> no dmar_req; dmar_irq pulse one cycle after DONE entry.
- Abort: start playback with COUNT=10; after 4 acks write 0x00=0 -> req drops next cycle; no irq; a new START with en=0 is ignored.
- Concurrent and illegal writes: both channels run with equal counts and ack high -> irqs pulse same cycle. Writing DMAR_ADDR mid-BUSY leaves the address sequence unchanged. Unmapped offset 0x3C has no effect.
- Reset mid-BUSY: rst for 1 cycle -> req, addr, irq all 0; a fresh START from reset values yields no req (COUNT=0 gives DONE only if en=1, and en=0 after reset so START is ignored).
